io_port_ctrl: RTL

IO_PORT_CTRL -- requirements
Module: io_port_ctrl

---
 rtl/io_port_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/io_port_ctrl.sv
// io_port_ctrl
// Character I/O port for a simple accumulator CPU. The input side buffers
// characters from an external device in a small FIFO and exposes the head
// as INPR with the FGI flag. The output side holds one character from OUTR
// in a holding register and hands it to the external device with a
// valid/ready handshake, exposing the FGO flag. irq is raised when
// interrupts are enabled and either flag is set.
//
// State table (output FSM)
//   state  | meaning
//   S_IDLE | holding register free, FGO=1, nothing offered to the device
//   S_BUSY | character held in ext_out_data, ext_out_valid=1, FGO=0
//
// Ports
//   clock          sole clock, rising edge
//   reset          asynchronous, active-low reset
//   ext_in_data    character from the external input device
//   ext_in_valid   ext_in_data valid this cycle
//   ext_in_ready   a character can be accepted this cycle
//   INPR           head of the input FIFO (zero when empty)
//   FGI            input flag, FIFO not empty
//   cpu_inp_ack    CPU consumed INPR (one-cycle pulse)
//   OUTR           CPU output register value
//   cpu_out_wr     CPU executed OUT (one-cycle pulse)
//   FGO            output flag, holding register free
//   ext_out_data   character offered to the external output device
//   ext_out_valid  ext_out_data valid
//   ext_out_ready  output device accepts ext_out_data this cycle
//   IEN            CPU interrupt enable
//   irq            registered interrupt request
//   in_err         sticky, pop requested on an empty FIFO
//   out_err        sticky, write requested while FGO=0
module io_port_ctrl #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] ext_in_data,
    input  logic              ext_in_valid,
    output logic              ext_in_ready,
    output logic [DATA_W-1:0] INPR,
    output logic              FGI,
    input  logic              cpu_inp_ack,
    input  logic [DATA_W-1:0] OUTR,
    input  logic              cpu_out_wr,
    output logic              FGO,
    output logic [DATA_W-1:0] ext_out_data,
    output logic              ext_out_valid,
    input  logic              ext_out_ready,
    input  logic              IEN,
    output logic              irq,
    output logic              in_err,
    output logic              out_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } out_state_t;

    // ---------------------------------------------------------------
    // Input FIFO
    // ---------------------------------------------------------------
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              push;
    logic              pop;

    // Ready looks only at the registered count, so a pop in the same
    // cycle never makes room for a push at a full FIFO.
    assign ext_in_ready = (count < DEPTH_C);
    assign FGI          = (count != '0);
    assign push         = ext_in_valid & ext_in_ready;
    assign pop          = cpu_inp_ack & FGI;
    assign INPR         = FGI ? mem[rd_ptr] : '0;

    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Storage is left unreset; INPR is masked to zero while empty.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= ext_in_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            in_err <= 1'b0;
        end else begin
            count <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (cpu_inp_ack && !FGI) begin
                in_err <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Output holding register FSM
    // ---------------------------------------------------------------
    out_state_t state_q;
    out_state_t state_next;
    logic       out_capture;
    logic       out_drop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next    = state_q;
        out_capture   = 1'b0;
        out_drop      = 1'b0;
        FGO           = 1'b0;
        ext_out_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                FGO = 1'b1;
                if (cpu_out_wr) begin
                    out_capture = 1'b1;
                    state_next  = S_BUSY;
                end
            end
            S_BUSY: begin
                ext_out_valid = 1'b1;
                // A write while busy is always lost, even on the cycle the
                // device takes the held character.
                out_drop      = cpu_out_wr;
                if (ext_out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ext_out_data <= '0;
            out_err      <= 1'b0;
        end else begin
            if (out_capture) begin
                ext_out_data <= OUTR;
            end
            if (out_drop) begin
                out_err <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Interrupt request, built from the flag values that take effect at
    // this edge so irq lines up with FGI/FGO rather than lagging them.
    // ---------------------------------------------------------------
    logic fgi_next;
    logic fgo_next;

    assign fgi_next = (count_next != '0);
    assign fgo_next = (state_next == S_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq <= 1'b0;
        end else begin
            irq <= IEN & (fgi_next | fgo_next);
        end
    end

endmodule
